// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller and its consumers.
//
// Contents:
//   DEFAULT_DATA_WIDTH       instruction word width
//   DEFAULT_IMEM_ADDR_WIDTH  imem word-address width
//   DEFAULT_PC_WIDTH         program counter width
//   DEFAULT_RESET_PC         first fetch address after reset
//   fetch_entry_t            {pc, instr} record handed from fetch to decode
package imem_fetch_ctrl_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  localparam int DEFAULT_IMEM_ADDR_WIDTH = 8;

  localparam int DEFAULT_PC_WIDTH = 32;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [DEFAULT_PC_WIDTH-1:0]   pc;
    logic [DEFAULT_DATA_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/imem_fetch_ctrl_fifo.sv
// fetch_fifo: small synchronous FIFO holding fetched {pc, instr} entries.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   flush      empties the FIFO; wins over a push in the same cycle
//   push       write push_data (ignored when full and not popping)
//   push_data  entry to write
//   pop        advance the head (ignored when empty)
//   head       entry at the head (valid when count != 0)
//   count      number of stored entries, 0..DEPTH
module fetch_fifo #(
  parameter type DATA_T = logic [63:0],
  parameter int  DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  DATA_T                    push_data,
  input  logic                     pop,
  output DATA_T                    head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_V = CW'(DEPTH);

  DATA_T          mem [DEPTH];
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic           push_ok;
  logic           pop_ok;

  // Qualify push/pop against occupancy so a stray request cannot corrupt the pointers.
  always_comb begin
    pop_ok  = pop && (count != {CW{1'b0}});
    push_ok = push && ((count < DEPTH_V) || pop_ok);
  end

  // Pointer and occupancy update; reset and flush both empty the FIFO.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count    <= {CW{1'b0}};
    end else begin
      if (push_ok) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_ok) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Entry storage; contents are qualified by count so they need no reset.
  always_ff @(posedge clk) begin
    if (push_ok && !flush && !rst) begin
      mem[wr_ptr_r] <= push_data;
    end
  end

  assign head = mem[rd_ptr_r];

endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: drives a synchronous-read instruction memory and feeds
// decode with {pc, instr} over a valid/ready handshake.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   redirect_valid/_pc    load a new fetch PC (low two bits ignored), flushing the pipe
//   imem_address          word address to imem, straight from fetch_pc
//   imem_read_data(_valid) imem response for the address presented last cycle
//   instr_valid/_ready    handshake with decode
//   instr_data, instr_pc  instruction at the FIFO head and its PC (zero when not valid)
//   perf_fetched/_flushed only with IMEM_FETCH_PERF_EN: pops, and entries/inflight
//                         discarded by redirects
//
// Optional feature macro: IMEM_FETCH_PERF_EN.
//
// One fetch may be outstanding. An issue is only made when the FIFO is sure
// to have room for its response, so a push is never lost. A response marked
// invalid is dropped and its PC re-fetched, keeping the stream contiguous.
module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int                    DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int                    ADDR_WIDTH = DEFAULT_IMEM_ADDR_WIDTH,
  parameter int                    PC_WIDTH   = DEFAULT_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0]   RESET_PC   = PC_WIDTH'(DEFAULT_RESET_PC),
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic [ADDR_WIDTH-1:0] imem_address,
  input  logic [DATA_WIDTH-1:0] imem_read_data,
  input  logic                  imem_read_data_valid,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [PC_WIDTH-1:0]   instr_pc
`ifdef IMEM_FETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_flushed
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_V = (CW + 1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [DATA_WIDTH-1:0] instr;
  } entry_t;

  logic [PC_WIDTH-1:0] fetch_pc_r;
  logic [PC_WIDTH-1:0] inflight_pc_r;
  logic                inflight_r;
  logic [CW-1:0]       count;
  entry_t              head;
  entry_t              push_entry;
  logic                pop;
  logic                push;
  logic                drop;
  logic                issue;
  logic [CW:0]         occupancy;
  logic                unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Handshake, return handling and issue decision for this cycle.
  always_comb begin
    pop        = instr_valid && instr_ready;
    push       = inflight_r && imem_read_data_valid;
    drop       = inflight_r && !imem_read_data_valid;
    push_entry = '{pc: inflight_pc_r, instr: imem_read_data};
    // Entries the FIFO must still be able to hold after this cycle's pop.
    occupancy  = {1'b0, count} + (CW + 1)'(inflight_r) - (CW + 1)'(pop);
    issue      = !rst && !redirect_valid && !drop && (occupancy < DEPTH_V);
  end

  // Fetch PC and outstanding-request tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_r    <= RESET_PC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= {PC_WIDTH{1'b0}};
    end else if (redirect_valid) begin
      fetch_pc_r <= {redirect_pc[PC_WIDTH-1:2], 2'b00};
      inflight_r <= 1'b0;
    end else if (drop) begin
      // Rewind so the dropped word is requested again.
      fetch_pc_r <= inflight_pc_r;
      inflight_r <= 1'b0;
    end else if (issue) begin
      inflight_r    <= 1'b1;
      inflight_pc_r <= fetch_pc_r;
      fetch_pc_r    <= fetch_pc_r + PC_WIDTH'(4);
    end else begin
      inflight_r <= 1'b0;
    end
  end

  assign imem_address = fetch_pc_r[ADDR_WIDTH+1:2];

  fetch_fifo #(
    .DATA_T (entry_t),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  // Decode-facing outputs; zeroed whenever the head is not valid.
  always_comb begin
    instr_valid = (count != {CW{1'b0}});
    if (instr_valid) begin
      instr_data = head.instr;
      instr_pc   = head.pc;
    end else begin
      instr_data = {DATA_WIDTH{1'b0}};
      instr_pc   = {PC_WIDTH{1'b0}};
    end
  end

`ifdef IMEM_FETCH_PERF_EN
  // Performance counters: pops, and work thrown away by redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= 32'h0000_0000;
      perf_flushed <= 32'h0000_0000;
    end else begin
      perf_fetched <= perf_fetched + 32'(pop);
      if (redirect_valid) begin
        // A coinciding pop was delivered, so it is not counted as discarded.
        perf_flushed <= perf_flushed + 32'(count) + 32'(inflight_r) - 32'(pop);
      end else begin
        perf_flushed <= perf_flushed;
      end
    end
  end
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed self-checking bench for imem_fetch_ctrl (ADDR_WIDTH = 8, FIFO_DEPTH = 2).
// The imem model returns the word address as data: imem[i] = i.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_imem_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [7:0]  imem_address;
  logic [31:0] imem_read_data;
  logic        imem_read_data_valid;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
`ifdef IMEM_FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  int passed;
  int total;

  imem_fetch_ctrl #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (8),
    .PC_WIDTH   (32),
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .redirect_valid       (redirect_valid),
    .redirect_pc          (redirect_pc),
    .imem_address         (imem_address),
    .imem_read_data       (imem_read_data),
    .imem_read_data_valid (imem_read_data_valid),
    .instr_valid          (instr_valid),
    .instr_ready          (instr_ready),
    .instr_data           (instr_data),
    .instr_pc             (instr_pc)
`ifdef IMEM_FETCH_PERF_EN
    ,
    .perf_fetched         (perf_fetched),
    .perf_flushed         (perf_flushed)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read imem: data for last cycle's address, contents imem[i] = i.
  always @(posedge clk) imem_read_data <= {24'h00_0000, imem_address};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0000_0000;
    instr_ready = 1'b1; imem_read_data_valid = 1'b1;
    tick(); tick();
    total = total + 1;
    if ({instr_valid, instr_pc, instr_data} !== {1'b0, 32'h0000_0000, 32'h0000_0000})
      $display("FAIL reset_outputs: got v=%0b pc=%h data=%h, expected v=0 pc=0 data=0",
               instr_valid, instr_pc, instr_data);
    else passed = passed + 1;
    total = total + 1;
    if (imem_address !== 8'h00)
      $display("FAIL reset_address: got %h expected 00", imem_address);
    else passed = passed + 1;
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      total = total + 1;
      if (instr_valid !== 1'b0)
        $display("FAIL stream_latency: cycle %0d got valid=%0b expected 0", c, instr_valid);
      else passed = passed + 1;
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'(4 * i);
      total = total + 1;
      if ({instr_valid, instr_pc, instr_data} !== {1'b1, exp_pc, 32'(i)})
        $display("FAIL stream_word%0d: got v=%0b pc=%h data=%h, expected v=1 pc=%h data=%h",
                 i, instr_valid, instr_pc, instr_data, exp_pc, 32'(i));
      else passed = passed + 1;
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc;
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total = total + 1;
      if ({instr_valid, instr_pc, instr_data} !== {1'b1, 32'h0000_000C, 32'h0000_0003})
        $display("FAIL stall_hold%0d: got v=%0b pc=%h data=%h, expected v=1 pc=0000000c data=00000003",
                 i, instr_valid, instr_pc, instr_data);
      else passed = passed + 1;
      if (i == 4) begin
        total = total + 1;
        if (imem_address !== 8'h05)
          $display("FAIL stall_no_issue: got address %h expected 05", imem_address);
        else passed = passed + 1;
      end
      tick();
    end
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_pc = 32'h0000_000C + 32'(4 * i);
      total = total + 1;
      if ({instr_valid, instr_pc, instr_data} !== {1'b1, exp_pc, exp_pc >> 2})
        $display("FAIL release_word%0d: got v=%0b pc=%h data=%h, expected v=1 pc=%h data=%h",
                 i, instr_valid, instr_pc, instr_data, exp_pc, exp_pc >> 2);
      else passed = passed + 1;
      tick();
    end
  endtask

  task automatic test_dropped_return();
    imem_read_data_valid = 1'b0;
    total = total + 1;
    if ({instr_valid, instr_pc, instr_data} !== {1'b1, 32'h0000_001C, 32'h0000_0007})
      $display("FAIL drop_head: got v=%0b pc=%h data=%h, expected v=1 pc=0000001c data=00000007",
               instr_valid, instr_pc, instr_data);
    else passed = passed + 1;
    tick();
    imem_read_data_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      total = total + 1;
      if (instr_valid !== 1'b0)
        $display("FAIL drop_bubble%0d: got valid=%0b expected 0", c, instr_valid);
      else passed = passed + 1;
      tick();
    end
    total = total + 1;
    if ({instr_valid, instr_pc, instr_data} !== {1'b1, 32'h0000_0020, 32'h0000_0008})
      $display("FAIL drop_refetch: got v=%0b pc=%h data=%h, expected v=1 pc=00000020 data=00000008",
               instr_valid, instr_pc, instr_data);
    else passed = passed + 1;
    tick();
    total = total + 1;
    if ({instr_valid, instr_pc, instr_data} !== {1'b1, 32'h0000_0024, 32'h0000_0009})
      $display("FAIL drop_next: got v=%0b pc=%h data=%h, expected v=1 pc=00000024 data=00000009",
               instr_valid, instr_pc, instr_data);
    else passed = passed + 1;
    tick();
  endtask

  task automatic test_redirect_full();
    instr_ready = 1'b0;
    total = total + 1;
    if ({instr_valid, instr_pc} !== {1'b1, 32'h0000_0028})
      $display("FAIL redir_pre_head: got v=%0b pc=%h, expected v=1 pc=00000028", instr_valid, instr_pc);
    else passed = passed + 1;
    tick();
    total = total + 1;
    if (imem_address !== 8'h0C)
      $display("FAIL redir_full_no_issue: got address %h expected 0c", imem_address);
    else passed = passed + 1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0; instr_ready = 1'b1;
    total = total + 1;
    if ({instr_valid, imem_address} !== {1'b0, 8'h40})
      $display("FAIL redir_flush: got v=%0b address=%h, expected v=0 address=40", instr_valid, imem_address);
    else passed = passed + 1;
    tick();
    total = total + 1;
    if (instr_valid !== 1'b0)
      $display("FAIL redir_bubble: got valid=%0b expected 0", instr_valid);
    else passed = passed + 1;
    tick();
    total = total + 1;
    if ({instr_valid, instr_pc, instr_data} !== {1'b1, 32'h0000_0100, 32'h0000_0040})
      $display("FAIL redir_target: got v=%0b pc=%h data=%h, expected v=1 pc=00000100 data=00000040",
               instr_valid, instr_pc, instr_data);
    else passed = passed + 1;
`ifdef IMEM_FETCH_PERF_EN
    total = total + 1;
    if ({perf_fetched, perf_flushed} !== {32'd10, 32'd2})
      $display("FAIL perf_after_redirect: got fetched=%0d flushed=%0d, expected fetched=10 flushed=2",
               perf_fetched, perf_flushed);
    else passed = passed + 1;
`endif
    tick();
    total = total + 1;
    if ({instr_valid, instr_pc, instr_data} !== {1'b1, 32'h0000_0104, 32'h0000_0041})
      $display("FAIL redir_follow: got v=%0b pc=%h data=%h, expected v=1 pc=00000104 data=00000041",
               instr_valid, instr_pc, instr_data);
    else passed = passed + 1;
    tick();
  endtask

  task automatic test_address_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_03FC;
    tick();
    redirect_valid = 1'b0;
    total = total + 1;
    if ({instr_valid, imem_address} !== {1'b0, 8'hFF})
      $display("FAIL wrap_top: got v=%0b address=%h, expected v=0 address=ff", instr_valid, imem_address);
    else passed = passed + 1;
    tick();
    total = total + 1;
    if ({instr_valid, imem_address} !== {1'b0, 8'h00})
      $display("FAIL wrap_zero: got v=%0b address=%h, expected v=0 address=00", instr_valid, imem_address);
    else passed = passed + 1;
    tick();
    total = total + 1;
    if ({instr_valid, instr_pc, instr_data} !== {1'b1, 32'h0000_03FC, 32'h0000_00FF})
      $display("FAIL wrap_last: got v=%0b pc=%h data=%h, expected v=1 pc=000003fc data=000000ff",
               instr_valid, instr_pc, instr_data);
    else passed = passed + 1;
    tick();
    total = total + 1;
    if ({instr_valid, instr_pc, instr_data} !== {1'b1, 32'h0000_0400, 32'h0000_0000})
      $display("FAIL wrap_pc: got v=%0b pc=%h data=%h, expected v=1 pc=00000400 data=00000000",
               instr_valid, instr_pc, instr_data);
    else passed = passed + 1;
    tick();
    total = total + 1;
    if ({instr_valid, instr_pc, instr_data} !== {1'b1, 32'h0000_0404, 32'h0000_0001})
      $display("FAIL wrap_next: got v=%0b pc=%h data=%h, expected v=1 pc=00000404 data=00000001",
               instr_valid, instr_pc, instr_data);
    else passed = passed + 1;
    tick();
  endtask

  task automatic test_reset_with_redirect();
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    rst = 1'b0; redirect_valid = 1'b0;
    total = total + 1;
    if ({instr_valid, instr_pc, instr_data, imem_address} !== {1'b0, 32'h0000_0000, 32'h0000_0000, 8'h00})
      $display("FAIL rst_redirect_clear: got v=%0b pc=%h data=%h address=%h, expected all zero",
               instr_valid, instr_pc, instr_data, imem_address);
    else passed = passed + 1;
`ifdef IMEM_FETCH_PERF_EN
    total = total + 1;
    if ({perf_fetched, perf_flushed} !== 64'h0)
      $display("FAIL perf_reset: got fetched=%0d flushed=%0d, expected 0 and 0", perf_fetched, perf_flushed);
    else passed = passed + 1;
`endif
    tick();
    total = total + 1;
    if (instr_valid !== 1'b0)
      $display("FAIL rst_resume_bubble: got valid=%0b expected 0", instr_valid);
    else passed = passed + 1;
    tick();
    total = total + 1;
    if ({instr_valid, instr_pc, instr_data} !== {1'b1, 32'h0000_0000, 32'h0000_0000})
      $display("FAIL rst_resume_first: got v=%0b pc=%h data=%h, expected v=1 pc=0 data=0",
               instr_valid, instr_pc, instr_data);
    else passed = passed + 1;
    tick();
    total = total + 1;
    if ({instr_valid, instr_pc, instr_data} !== {1'b1, 32'h0000_0004, 32'h0000_0001})
      $display("FAIL rst_resume_second: got v=%0b pc=%h data=%h, expected v=1 pc=00000004 data=00000001",
               instr_valid, instr_pc, instr_data);
    else passed = passed + 1;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_dropped_return();
    test_redirect_full();
    test_address_wrap();
    test_reset_with_redirect();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
